// File: rtl/mem_arbiter_n.sv
// -----------------------------------------------------------------------------
// mem_arbiter_n
// N-channel cacheline arbiter. It grants one requester at a time and holds the
// grant for the whole transaction. It registers the winning request onto a
// single downstream line port and routes the downstream response back to the
// winner.
//
// Build option:
//   ARB_RR_EN  defined   -> round-robin arbitration with a rotating pointer
//              undefined -> fixed priority, lowest requesting index wins
//
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   ch_read         per-channel read request (level, held until ch_resp)
//   ch_write        per-channel write request (level); read+write means write
//   ch_address      packed per-channel addresses, channel i at [i*ADDR_W +: ADDR_W]
//   ch_wdata        packed per-channel write lines, channel i at [i*LINE_W +: LINE_W]
//   ch_rdata        read line broadcast to all channels, pass-through of mem_rdata
//   ch_resp         one-hot completion pulse to the granted channel
//   mem_read/write  registered downstream command, never both set
//   mem_address     registered downstream address
//   mem_wdata       registered downstream write line
//   mem_rdata       downstream read line
//   mem_resp        downstream completion pulse
//   grant_valid     a channel currently owns the downstream port
//   grant_id        index of the owning channel, 0 when idle
// -----------------------------------------------------------------------------
module mem_arbiter_n #(
    parameter int NUM_CH = 3,
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256,
    localparam int ID_W  = $clog2(NUM_CH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH-1:0]        ch_read,
    input  logic [NUM_CH-1:0]        ch_write,
    input  logic [NUM_CH*ADDR_W-1:0] ch_address,
    input  logic [NUM_CH*LINE_W-1:0] ch_wdata,
    output logic [LINE_W-1:0]        ch_rdata,
    output logic [NUM_CH-1:0]        ch_resp,
    output logic                     mem_read,
    output logic                     mem_write,
    output logic [ADDR_W-1:0]        mem_address,
    output logic [LINE_W-1:0]        mem_wdata,
    input  logic [LINE_W-1:0]        mem_rdata,
    input  logic                     mem_resp,
    output logic                     grant_valid,
    output logic [ID_W-1:0]          grant_id
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t              state;
    logic [NUM_CH-1:0]   req;
    logic                hit;
    logic [ID_W-1:0]     win;
    logic [ADDR_W-1:0]   win_address;
    logic [LINE_W-1:0]   win_wdata;
    logic                win_write;

`ifdef ARB_RR_EN
    logic [ID_W-1:0]     rr_ptr;
`endif

    assign req = ch_read | ch_write;

    // Winner selection. In round-robin mode the first pass only considers
    // channels at or above the pointer; the second pass picks the lowest
    // requester, which is the wrapped part of the search. Fixed priority is
    // just the second pass on its own.
    always_comb begin
        // NOTE: every variable assigned in always_comb gets a default first,
        // so no path leaves it unassigned and no latch is inferred.
        hit = 1'b0;
        win = '0;
`ifdef ARB_RR_EN
        for (int i = 0; i < NUM_CH; i++) begin
            if (!hit && req[i] && (ID_W'(i) >= rr_ptr)) begin
                hit = 1'b1;
                win = ID_W'(i);
            end
        end
`endif
        for (int i = 0; i < NUM_CH; i++) begin
            if (!hit && req[i]) begin
                hit = 1'b1;
                win = ID_W'(i);
            end
        end
    end

    // Fields of the winning channel. Comparing against each legal index means
    // a non-power-of-2 NUM_CH can never select a slice outside the buses.
    always_comb begin
        win_address = '0;
        win_wdata   = '0;
        win_write   = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (win == ID_W'(i)) begin
                win_address = ch_address[i*ADDR_W +: ADDR_W];
                win_wdata   = ch_wdata[i*LINE_W +: LINE_W];
                win_write   = ch_write[i];
            end
        end
    end

    // The response is routed combinationally so the requester sees it in the
    // same cycle as mem_resp. A stray mem_resp while IDLE is dropped here.
    always_comb begin
        ch_resp = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            ch_resp[i] = (state == BUSY) && mem_resp && (grant_id == ID_W'(i));
        end
    end

    assign ch_rdata = mem_rdata;

    // NOTE: sequential state is written with non-blocking assignments only,
    // so every register samples values from before the clock edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            mem_read    <= 1'b0;
            mem_write   <= 1'b0;
            mem_address <= '0;
            mem_wdata   <= '0;
            grant_valid <= 1'b0;
            grant_id    <= '0;
`ifdef ARB_RR_EN
            rr_ptr      <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (hit) begin
                        grant_valid <= 1'b1;
                        grant_id    <= win;
                        mem_address <= win_address;
                        mem_wdata   <= win_wdata;
                        mem_write   <= win_write;
                        mem_read    <= ~win_write;
                        state       <= BUSY;
                    end
                end
                BUSY: begin
                    // Channel inputs are ignored here; the downstream request
                    // stays exactly as latched until the completion arrives.
                    if (mem_resp) begin
                        mem_read    <= 1'b0;
                        mem_write   <= 1'b0;
                        grant_valid <= 1'b0;
                        grant_id    <= '0;
`ifdef ARB_RR_EN
                        if (grant_id == ID_W'(NUM_CH - 1)) begin
                            rr_ptr <= '0;
                        end else begin
                            rr_ptr <= grant_id + 1'b1;
                        end
`endif
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter_n.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter_n
// Self-checking bench for mem_arbiter_n. A transaction-level reference model
// (pending requests, a policy function and the current owner) predicts every
// output each cycle. Directed scenarios cover reset, a single write, two-way
// contention, continuous three-way traffic, input changes while busy and
// reset while busy; a randomized phase then mixes all of them.
// Honors ARB_RR_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_mem_arbiter_n;

    localparam int NUM_CH = 3;
    localparam int ADDR_W = 32;
    localparam int LINE_W = 256;
    localparam int ID_W   = $clog2(NUM_CH);

    typedef logic [LINE_W-1:0] val_t;

    logic                     clk = 1'b0;
    logic                     rst = 1'b1;
    logic [NUM_CH-1:0]        ch_read = '0;
    logic [NUM_CH-1:0]        ch_write = '0;
    logic [NUM_CH*ADDR_W-1:0] ch_address;
    logic [NUM_CH*LINE_W-1:0] ch_wdata;
    logic [LINE_W-1:0]        ch_rdata;
    logic [NUM_CH-1:0]        ch_resp;
    logic                     mem_read;
    logic                     mem_write;
    logic [ADDR_W-1:0]        mem_address;
    logic [LINE_W-1:0]        mem_wdata;
    logic [LINE_W-1:0]        mem_rdata = '0;
    logic                     mem_resp = 1'b0;
    logic                     grant_valid;
    logic [ID_W-1:0]          grant_id;

    logic [ADDR_W-1:0] addr_a  [NUM_CH];
    logic [LINE_W-1:0] wdata_a [NUM_CH];

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            ch_address[i*ADDR_W +: ADDR_W] = addr_a[i];
            ch_wdata[i*LINE_W +: LINE_W]   = wdata_a[i];
        end
    end

    mem_arbiter_n #(
        .NUM_CH(NUM_CH),
        .ADDR_W(ADDR_W),
        .LINE_W(LINE_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ch_read    (ch_read),
        .ch_write   (ch_write),
        .ch_address (ch_address),
        .ch_wdata   (ch_wdata),
        .ch_rdata   (ch_rdata),
        .ch_resp    (ch_resp),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_address(mem_address),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_resp   (mem_resp),
        .grant_valid(grant_valid),
        .grant_id   (grant_id)
    );

    // Reference model: who owns the port and what was latched for it.
    bit                m_busy  = 1'b0;
    int                m_gid   = 0;
    bit                m_read  = 1'b0;
    bit                m_write = 1'b0;
    logic [ADDR_W-1:0] m_addr  = '0;
    logic [LINE_W-1:0] m_wdata = '0;
    int                m_ptr   = 0;

    int n_checks = 0;
    int n_errors = 0;
    int dut_grants[$];
    bit prev_gv = 1'b0;

    task automatic check(input string tag, input val_t got, input val_t exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int pick(input logic [NUM_CH-1:0] r, input int ptr);
`ifdef ARB_RR_EN
        for (int k = 0; k < NUM_CH; k++) begin
            if (r[(ptr + k) % NUM_CH]) return (ptr + k) % NUM_CH;
        end
`else
        for (int c = 0; c < NUM_CH; c++) begin
            if (r[c]) return c;
        end
`endif
        return -1;
    endfunction

    function automatic logic [LINE_W-1:0] rand_line();
        logic [LINE_W-1:0] v;
        for (int i = 0; i < LINE_W / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // One clock cycle: compare every output against the model, advance the
    // model with the inputs present before the edge, clock, and apply the
    // requester contract (drop the request at the edge where ch_resp is seen).
    task automatic cycle();
        logic [NUM_CH-1:0] exp_resp;
        int g;
        int g_resp;
        #1;
        exp_resp = '0;
        if (m_busy && mem_resp) exp_resp = NUM_CH'(1) << m_gid;
        check("ch_resp",     val_t'(ch_resp),     val_t'(exp_resp));
        check("ch_rdata",    val_t'(ch_rdata),    val_t'(mem_rdata));
        check("mem_read",    val_t'(mem_read),    val_t'(m_read));
        check("mem_write",   val_t'(mem_write),   val_t'(m_write));
        check("mem_address", val_t'(mem_address), val_t'(m_addr));
        check("mem_wdata",   val_t'(mem_wdata),   val_t'(m_wdata));
        check("grant_valid", val_t'(grant_valid), val_t'(m_busy));
        check("grant_id",    val_t'(grant_id),    val_t'(m_gid));
        if (grant_valid === 1'b1 && !prev_gv) dut_grants.push_back(int'(grant_id));
        prev_gv = (grant_valid === 1'b1);

        g_resp = -1;
        if (rst) begin
            m_busy = 0; m_gid = 0; m_read = 0; m_write = 0;
            m_addr = '0; m_wdata = '0; m_ptr = 0;
        end else if (!m_busy) begin
            g = pick(ch_read | ch_write, m_ptr);
            if (g >= 0) begin
                m_busy  = 1;
                m_gid   = g;
                m_addr  = addr_a[g];
                m_wdata = wdata_a[g];
                m_write = ch_write[g];
                m_read  = !ch_write[g];
            end
        end else if (mem_resp) begin
            g_resp  = m_gid;
            m_ptr   = (m_gid + 1) % NUM_CH;
            m_busy  = 0; m_gid = 0; m_read = 0; m_write = 0;
        end

        @(posedge clk);
        #1;
        if (g_resp >= 0) begin
            ch_read[g_resp]  = 1'b0;
            ch_write[g_resp] = 1'b0;
        end
    endtask

    // Let a granted transaction sit busy for some cycles, then complete it.
    task automatic txn_tail(input int busy_cycles);
        repeat (busy_cycles) cycle();
        mem_resp  = 1'b1;
        mem_rdata = rand_line();
        cycle();
        mem_resp  = 1'b0;
    endtask

    task automatic check_order(input string tag, input int exp[$]);
        check({tag, "_count"}, val_t'(dut_grants.size()), val_t'(exp.size()));
        for (int i = 0; i < exp.size(); i++) begin
            if (i < dut_grants.size()) check(tag, val_t'(dut_grants[i]), val_t'(exp[i]));
        end
    endtask

    initial begin
        int exp_q[$];
        int busy_cnt;
        int delay;
        int kind;
        logic [ADDR_W-1:0] held_addr;
        logic [LINE_W-1:0] held_wdata;
        logic [LINE_W-1:0] beef_line;

        for (int i = 0; i < NUM_CH; i++) begin
            addr_a[i]  = $urandom;
            wdata_a[i] = rand_line();
        end

        // Reset with every channel reading; outputs are 0 throughout.
        rst = 1'b1;
        ch_read = '1;
        @(posedge clk);
        #1;
        cycle();
        cycle();
        check("rst_mem_read",    val_t'(mem_read),    val_t'(0));
        check("rst_grant_valid", val_t'(grant_valid), val_t'(0));
        rst = 1'b0;
        dut_grants.delete();
        cycle();
        check("first_mem_read",    val_t'(mem_read),    val_t'(1));
        check("first_grant_id",    val_t'(grant_id),    val_t'(0));
        check("first_mem_address", val_t'(mem_address), val_t'(addr_a[0]));
        txn_tail(2);
        cycle();
        txn_tail(2);
        cycle();
        txn_tail(2);
        cycle();
        exp_q = {0, 1, 2};
        check_order("reset_order", exp_q);

        // Single write on channel 1, response five cycles after it appears.
        beef_line  = {16'hDEAD, 224'd0, 16'hBEEF};
        addr_a[1]  = 32'h0000_1A20;
        wdata_a[1] = beef_line;
        ch_write[1] = 1'b1;
        cycle();
        check("wr_mem_write",   val_t'(mem_write),   val_t'(1));
        check("wr_mem_read",    val_t'(mem_read),    val_t'(0));
        check("wr_mem_address", val_t'(mem_address), val_t'(32'h0000_1A20));
        check("wr_mem_wdata",   val_t'(mem_wdata),   beef_line);
        repeat (4) cycle();
        mem_resp = 1'b1;
        #1;
        check("wr_ch_resp", val_t'(ch_resp), val_t'(3'b010));
        cycle();
        mem_resp = 1'b0;
        check("wr_mem_write_after", val_t'(mem_write), val_t'(0));

        // Channels 0 and 2 read together, one IDLE cycle between them.
        dut_grants.delete();
        ch_read[0] = 1'b1;
        ch_read[2] = 1'b1;
        cycle();
        txn_tail(2);
        check("gap_grant_valid", val_t'(grant_valid), val_t'(0));
        cycle();
        txn_tail(2);
        cycle();
`ifdef ARB_RR_EN
        exp_q = {2, 0};
`else
        exp_q = {0, 2};
`endif
        check_order("pair_order", exp_q);

        // Continuous reading on all channels from a fresh reset; a finished
        // channel re-raises its request right after the IDLE cycle.
        rst = 1'b1;
        ch_read = '1;
        cycle();
        rst = 1'b0;
        dut_grants.delete();
        begin
            int last;
            last = -1;
            for (int t = 0; t < 6; t++) begin
                cycle();
                if (last >= 0) ch_read[last] = 1'b1;
                cycle();
                mem_resp  = 1'b1;
                mem_rdata = rand_line();
                last = m_gid;
                cycle();
                mem_resp = 1'b0;
            end
        end
        ch_read = '0;
        cycle();
`ifdef ARB_RR_EN
        exp_q = {0, 1, 2, 0, 1, 2};
`else
        exp_q = {0, 1, 0, 1, 0, 1};
`endif
        check_order("stream_order", exp_q);

        // Channel 0 busy while its inputs change and channel 1 requests.
        addr_a[0]  = $urandom;
        wdata_a[0] = rand_line();
        held_addr  = addr_a[0];
        held_wdata = wdata_a[0];
        ch_read[0] = 1'b1;
        cycle();
        addr_a[0]  = ~held_addr;
        wdata_a[0] = ~held_wdata;
        ch_write[1] = 1'b1;
        cycle();
        cycle();
        check("busy_held_address", val_t'(mem_address), val_t'(held_addr));
        check("busy_held_wdata",   val_t'(mem_wdata),   held_wdata);
        txn_tail(1);
        check("busy_gap_valid", val_t'(grant_valid), val_t'(0));
        cycle();
        check("busy_next_valid", val_t'(grant_valid), val_t'(1));
        check("busy_next_id",    val_t'(grant_id),    val_t'(1));
        txn_tail(1);
        cycle();

        // Read+write on channel 0, then reset in the middle of it.
        ch_read[0]  = 1'b1;
        ch_write[0] = 1'b1;
        cycle();
        check("both_mem_write", val_t'(mem_write), val_t'(1));
        check("both_mem_read",  val_t'(mem_read),  val_t'(0));
        cycle();
        rst = 1'b1;
        ch_read[0]  = 1'b0;
        ch_write[0] = 1'b0;
        cycle();
        rst = 1'b0;
        check("abort_mem_write",   val_t'(mem_write),   val_t'(0));
        check("abort_grant_valid", val_t'(grant_valid), val_t'(0));
        mem_resp = 1'b1;
        #1;
        check("stray_ch_resp", val_t'(ch_resp), val_t'(0));
        cycle();
        mem_resp = 1'b0;
        cycle();

        // Randomized traffic with stray responses and occasional resets.
        busy_cnt = 0;
        delay    = 1;
        for (int n = 0; n < 2000; n++) begin
            rst = ($urandom_range(0, 199) == 0);
            for (int c = 0; c < NUM_CH; c++) begin
                if (!(ch_read[c] | ch_write[c])) begin
                    if ($urandom_range(0, 3) == 0) begin
                        kind        = $urandom_range(0, 2);
                        ch_read[c]  = (kind != 1);
                        ch_write[c] = (kind != 0);
                        addr_a[c]   = $urandom;
                        wdata_a[c]  = rand_line();
                    end
                end else if ($urandom_range(0, 3) == 0) begin
                    addr_a[c]  = $urandom;
                    wdata_a[c] = rand_line();
                end
            end
            if (!m_busy) begin
                busy_cnt = 0;
                delay    = $urandom_range(1, 6);
            end
            if (rst) begin
                mem_resp = 1'b0;
            end else if (m_busy) begin
                busy_cnt++;
                mem_resp = (busy_cnt >= delay);
            end else begin
                mem_resp = ($urandom_range(0, 7) == 0);
            end
            mem_rdata = rand_line();
            cycle();
        end

        rst      = 1'b0;
        mem_resp = 1'b0;
        ch_read  = '0;
        ch_write = '0;
        repeat (3) cycle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
